// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide external RAM/IO port.
//
// Two requesters share the port:
//   - ICache: 16-byte block reads, assembled little-endian into ic_data.
//   - Load/store buffer (LSB): 1/2/4-byte loads and stores.
// Each source may have one outstanding request. It is latched on its query
// pulse, arbitrated in IDLE, and then sequenced one byte per cycle.
//
// Handshake: *_query_en is a one-cycle request pulse. It is accepted only when
// that source has nothing pending or in service. ic_data_en / lsb_done are
// one-cycle completion pulses, and a new request may be pulsed in that same
// cycle. There is no ready signal; a pulse that arrives while the source is
// busy is dropped.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties.
// The default build uses fixed priority, with the LSB winning ties.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (0 = pause, all state holds)
//   mem_din/mem_dout/mem_a/mem_wr : external byte port (read data 1 cycle late)
//   io_buffer_full                : stalls writes to IO space (addr[17:16]==IO_ADDR_HI)
//   clear_in                      : fetch flush, drops/aborts ICache work
//   ic_query_en/ic_query_addr     : ICache block request
//   ic_data_en/ic_data            : ICache block response
//   lsb_query_en/lsb_is_write/lsb_addr/lsb_size/lsb_wdata : LSB request
//   lsb_done/lsb_rdata            : LSB completion, zero-extended load data
//   dbg_state_o                   : current FSM state (0 IDLE, 1 IC_READ, 2 LS_READ, 3 LS_WRITE)
module mem_arbiter #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter logic [1:0]  IO_ADDR_HI  = 2'b11
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [31:0]                mem_a,
  output logic                       mem_wr,
  input  logic                       io_buffer_full,
  input  logic                       clear_in,
  input  logic                       ic_query_en,
  input  logic [31:0]                ic_query_addr,
  output logic                       ic_data_en,
  output logic [8*BLOCK_BYTES-1:0]   ic_data,
  input  logic                       lsb_query_en,
  input  logic                       lsb_is_write,
  input  logic [31:0]                lsb_addr,
  input  logic [1:0]                 lsb_size,
  input  logic [31:0]                lsb_wdata,
  output logic                       lsb_done,
  output logic [31:0]                lsb_rdata,
  output logic [1:0]                 dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_READ  = 2'd1,
    LS_READ  = 2'd2,
    LS_WRITE = 2'd3
  } state_e;

  localparam logic [4:0] BLK_N = 5'(BLOCK_BYTES);

  state_e      state_q;
  logic [4:0]  cnt_q;          // cycles spent in the current transfer state
  logic        ic_pend_q;
  logic        lsb_pend_q;
  logic [31:0] ic_addr_q;
  logic [31:0] lsb_addr_q;
  logic [31:0] lsb_wdata_q;
  logic        lsb_we_q;
  logic [2:0]  lsb_n_q;
  logic [7:0]  buf_q [BLOCK_BYTES];
  logic [7:0]  mem_dout_q;
  logic [31:0] mem_a_q;
  logic        mem_wr_q;
  logic        ic_data_en_q;
  logic [8*BLOCK_BYTES-1:0] ic_data_q;
  logic        lsb_done_q;
  logic [31:0] lsb_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic        last_ls_q;      // 1 = LSB was granted most recently
`endif

  logic [4:0]  xfer_n;
  logic        io_stall;
  logic        ic_take;
  logic        grant_ls;
  logic        grant_ic;
  logic        ic_accept;
  logic        ls_accept;
  logic [2:0]  req_n;
  logic [1:0]  wr_sel;
  logic [8*BLOCK_BYTES-1:0] fill_blk;

  always_comb begin
    xfer_n = (state_q == IC_READ) ? BLK_N : {2'b00, lsb_n_q};
  end

  // A write to IO space waits while the UART buffer is full; reads never stall.
  assign io_stall = mem_wr_q && (mem_a_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign mem_wr   = mem_wr_q && rdy_in && !io_stall;

  // A flush in the same cycle as selection drops the ICache request.
  assign ic_take = ic_pend_q && !clear_in;

`ifdef MEM_ARB_RR_EN
  assign grant_ls = (state_q == IDLE) && lsb_pend_q && (!ic_take || !last_ls_q);
`else
  assign grant_ls = (state_q == IDLE) && lsb_pend_q;
`endif
  assign grant_ic = (state_q == IDLE) && ic_take && !grant_ls;

  // A query during a flush is the post-redirect fetch and replaces any old one.
  assign ic_accept = ic_query_en && (clear_in || (!ic_pend_q && state_q != IC_READ));
  assign ls_accept = lsb_query_en && !lsb_pend_q &&
                     (state_q != LS_READ) && (state_q != LS_WRITE);

  always_comb begin
    case (lsb_size)
      2'd0:    req_n = 3'd1;
      2'd1:    req_n = 3'd2;
      default: req_n = 3'd4;   // size 3 is illegal and handled as a word
    endcase
  end

  assign wr_sel = cnt_q[1:0] + 2'd1;

  // Block with the byte arriving this cycle merged in. This is used on the
  // final capture cycle so that the response includes the last byte.
  always_comb begin
    fill_blk = '0;
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      fill_blk[8*i +: 8] = (cnt_q == 5'(i + 1)) ? mem_din : buf_q[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ic_pend_q    <= 1'b0;
      lsb_pend_q   <= 1'b0;
      ic_addr_q    <= '0;
      lsb_addr_q   <= '0;
      lsb_wdata_q  <= '0;
      lsb_we_q     <= 1'b0;
      lsb_n_q      <= '0;
      for (int i = 0; i < int'(BLOCK_BYTES); i++) buf_q[i] <= '0;
      mem_dout_q   <= '0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      ic_data_en_q <= 1'b0;
      ic_data_q    <= '0;
      lsb_done_q   <= 1'b0;
      lsb_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q    <= 1'b0;
`endif
    end else if (rdy_in) begin
      ic_data_en_q <= 1'b0;
      lsb_done_q   <= 1'b0;

      if (ic_accept) begin
        ic_pend_q <= 1'b1;
        ic_addr_q <= ic_query_addr & ~32'hF;
      end else if (clear_in || grant_ic) begin
        ic_pend_q <= 1'b0;
      end

      if (ls_accept) begin
        lsb_pend_q  <= 1'b1;
        lsb_addr_q  <= lsb_addr;
        lsb_wdata_q <= lsb_wdata;
        lsb_we_q    <= lsb_is_write;
        lsb_n_q     <= req_n;
      end else if (grant_ls) begin
        lsb_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          for (int i = 0; i < int'(BLOCK_BYTES); i++) buf_q[i] <= '0;
          if (grant_ls) begin
`ifdef MEM_ARB_RR_EN
            last_ls_q <= 1'b1;
`endif
            mem_a_q <= lsb_addr_q;
            if (lsb_we_q) begin
              state_q    <= LS_WRITE;
              mem_dout_q <= lsb_wdata_q[7:0];
              mem_wr_q   <= 1'b1;
            end else begin
              state_q <= LS_READ;
            end
          end else if (grant_ic) begin
`ifdef MEM_ARB_RR_EN
            last_ls_q <= 1'b0;
`endif
            mem_a_q <= ic_addr_q;
            state_q <= IC_READ;
          end
        end

        IC_READ, LS_READ: begin
          if (state_q == IC_READ && clear_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == xfer_n) begin
            // Last byte arrives now; publish the whole result next cycle.
            state_q <= IDLE;
            cnt_q   <= '0;
            if (state_q == IC_READ) begin
              ic_data_en_q <= 1'b1;
              ic_data_q    <= fill_blk;
            end else begin
              lsb_done_q  <= 1'b1;
              lsb_rdata_q <= fill_blk[31:0];
            end
          end else begin
            // Cycle k captures byte k-1 and drives address k+1, if one remains.
            for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
              if (cnt_q == 5'(i + 1)) buf_q[i] <= mem_din;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q + 5'd1 < xfer_n) mem_a_q <= mem_a_q + 32'd1;
          end
        end

        LS_WRITE: begin
          if (!io_stall) begin
            if (cnt_q + 5'd1 == xfer_n) begin
              mem_wr_q    <= 1'b0;
              lsb_done_q  <= 1'b1;
              lsb_rdata_q <= '0;
              state_q     <= IDLE;
              cnt_q       <= '0;
            end else begin
              cnt_q      <= cnt_q + 5'd1;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= lsb_wdata_q[{wr_sel, 3'b000} +: 8];
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_dout    = mem_dout_q;
  assign mem_a       = mem_a_q;
  assign ic_data_en  = ic_data_en_q;
  assign ic_data     = ic_data_q;
  assign lsb_done    = lsb_done_q;
  assign lsb_rdata   = lsb_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external RAM/IO port.
- Serves two requesters:
  - ICache: 16-byte block reads.
  - Load/store buffer (LSB): 1/2/4-byte loads and stores.
- Latches one outstanding request per requester, arbitrates, and sequences the byte transfers.
- Assembles ICache blocks little-endian; handles IO back-pressure and instruction-fetch flush.

Parameters:
- BLOCK_BYTES, 16, bytes per ICache block (fixed by the ICache 128-bit interface).
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks IO space.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global run enable; 0 = pause.
- mem_din  in  8  RAM read byte; valid the cycle after its address is driven.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  UART buffer full; writes to IO space must stall.
- clear_in  in  1  fetch flush: aborts or drops the ICache request.
- ic_query_en  in  1  one-cycle pulse, ICache block request.
- ic_query_addr  in  32  block byte address; bits [3:0] ignored and treated as 0.
- ic_data_en  out  1  one-cycle pulse, block valid.
- ic_data  out  128  block; byte i at bits [8i+7:8i].
- lsb_query_en  in  1  one-cycle pulse, LSB request.
- lsb_is_write  in  1  1 = store.
- lsb_addr  in  32  byte address.
- lsb_size  in  2  0 = 1B, 1 = 2B, 2 = 4B; 3 is illegal, treated as 4B.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_done  out  1  one-cycle pulse, access complete.
- lsb_rdata  out  32  load data, zero-extended (LSB sign-extends); 0 for stores.

Behaviour:
- Reset (rst_in=1 at posedge): state IDLE, both pending flags 0, byte counter 0. All outputs 0: mem_a, mem_dout, mem_wr, ic_data_en, ic_data, lsb_done, lsb_rdata. Reset mid-transfer abandons it; no further mem_wr.
- rdy_in=0: all registers hold; mem_wr gated to 0 combinationally.
- Request capture:
  - An *_query_en sampled high sets that source's pending flag and latches its fields.
  - One outstanding request per source. A second pulse while pending or in service is a protocol violation and is ignored.
  - A new request may be issued in the same cycle the source's done/data_en pulse is visible.
- States: IDLE, IC_READ, LS_READ, LS_WRITE.
- IDLE:
  - If any pending flag is set, select a source (see Optional Feature), clear its pending flag, enter the matching state, drive byte 0 (mem_a, and for writes mem_dout and mem_wr=1), counter=0.
  - Requests pulsed in the current cycle are not yet visible to selection.
- IC_READ (N=16) / LS_READ (N=1/2/4):
  - Byte i address is driven in cycle s+i, where s is the first cycle of the state.
  - Byte i data (mem_din) is captured in cycle s+i+1.
  - Address count stops at N-1; mem_a then holds its last value.
  - After capturing byte N-1, pulse ic_data_en or lsb_done (lsb_rdata valid) in the following cycle, then return to IDLE.
- LS_WRITE:
  - Byte i: mem_a=addr+i, mem_dout=wdata[8i+7:8i], mem_wr=1, in cycle s+i.
  - In cycle s+N: mem_wr=0, lsb_done=1, back to IDLE.
- IO stall: while the address being written has addr[17:16]==IO_ADDR_HI and io_buffer_full=1:
  - mem_wr=0 and the counter holds.
  - Resume the same byte when io_buffer_full falls.
  - Reads of IO space are never stalled.
- Latency, uncontended, request pulsed in cycle t:
  - ic_data_en is visible in cycle t+19.
  - Load of N bytes: lsb_done visible in t+N+3.
  - Store of N bytes: lsb_done visible in t+N+2.
- clear_in:
  - Clears the ICache pending flag.
  - If in IC_READ, returns to IDLE next cycle; no ic_data_en and no partial data exposed.
  - An ic_query_en sampled in the same cycle as clear_in is accepted (post-redirect fetch).
  - LSB work is never affected.
- When not driving a byte, mem_wr=0. mem_a and mem_dout hold their previous values.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both sources are pending, grant the source not granted last; the last-granted register resets to ICache, so the first tie goes to LSB.
- MEM_ARB_RR_EN undefined: fixed priority, LSB always wins ties.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then ic_query_en with addr 0x1004 at cycle t -> mem_a steps 0x1000..0x100F over cycles t+2..t+17, mem_wr=0 throughout; ic_data_en=1 only at t+19; ic_data = RAM bytes 0x1000..0x100F little-endian.
- LSB store, size 2, addr 0x200, wdata 0xA1B2C3D4 -> mem_wr=1 with (0x200,0xD4) then (0x201,0xC3); lsb_done at t+4; a following 4-byte load of 0x200 returns lsb_rdata 0x????C3D4 with the upper bytes from RAM.
- Store 1B to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 during the stall; exactly one write of the byte after the flag drops; lsb_done the cycle after that write.
- ic_query_en and lsb_query_en in the same cycle -> default build services LSB first and ICache immediately after; RR build, repeated ties -> grants alternate LSB, IC, LSB, …
- clear_in asserted in the 8th byte cycle of IC_READ -> no ic_data_en; IDLE next cycle; a new ic_query_en in the clear cycle completes normally with the new block.
- rdy_in low for 3 cycles mid-store -> no mem_wr during the pause; the remaining bytes are written exactly once after resume.
